// File: rtl/wb_rom_loader_pkg.sv
// Shared definitions for the Wishbone ROM loader.
//   - FSM state encodings (3-bit localparams)
//   - err_code_o encodings
//   - word_addr(): byte address of a word index relative to a base address
package wb_rom_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FILL  = 3'd1;
  localparam state_t ST_WR    = 3'd2;
  localparam state_t ST_RD    = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERR   = 3'd6;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_WR_TMO = 2'd1;
  localparam logic [1:0] ERR_RD_TMO = 2'd2;
  localparam logic [1:0] ERR_CSUM   = 2'd3;

  // Words are 4 bytes apart on the bus.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [9:0] idx);
    return base + {20'h0_0000, idx, 2'b00};
  endfunction

endpackage

// File: rtl/wb_rom_loader_pack.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   clr_i           drop any partially assembled word
//   take_i          byte_i is accepted this cycle
//   byte_i          incoming byte
//   word_nxt_o      word contents including the byte being accepted now
//   full_o          the byte accepted this cycle completes a word
module wb_rom_loader_pack
  import wb_rom_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_nxt_o,
  output logic        full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for byte buffer and byte count.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = 32'h0000_0000;
      cnt_d  = 2'd0;
    end else if (take_i) begin
      case (cnt_q)
        2'd0:    word_d[7:0]   = byte_i;
        2'd1:    word_d[15:8]  = byte_i;
        2'd2:    word_d[23:16] = byte_i;
        2'd3:    word_d[31:24] = byte_i;
        default: word_d        = word_q;
      endcase
      cnt_d = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // Byte buffer and count registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // Exposing the next value lets the top launch the write on the cycle after the fourth byte.
  assign word_nxt_o = word_d;
  assign full_o     = take_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/wb_rom_loader.sv
// Streams bytes into 32-bit words, writes them over Wishbone, reads them back
// and compares 32-bit modular sums of written and read data.
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, synchronous active-low reset
//   start_i                begin a load (honoured in IDLE, DONE, ERR)
//   byte_i/byte_valid_i/byte_ready_o   byte stream handshake
//   wbm_*                  classic Wishbone master
//   busy_o, done_o, err_o, err_code_o  status
module wb_rom_loader
  import wb_rom_loader_pkg::*;
#(
  parameter int          WORDS     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam logic [9:0] IDX_LAST = 10'(WORDS - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] wsum_q, wsum_d, rsum_q, rsum_d;
  logic        done_q, done_d, err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        ready_q, busy_q;

  logic        take_s, pack_clr_s, pack_full_s;
  logic [31:0] pack_word_s;

  assign take_s = byte_valid_i && ready_q;

  wb_rom_loader_pack u_pack (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .clr_i      (pack_clr_s),
    .take_i     (take_s),
    .byte_i     (byte_i),
    .word_nxt_o (pack_word_s),
    .full_o     (pack_full_s)
  );

  // FSM next-state, bus launch/retire, sums and status.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    done_d     = done_q;
    err_d      = err_q;
    code_d     = code_q;
    pack_clr_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d    = ST_FILL;
          idx_d      = 10'd0;
          wsum_d     = 32'h0000_0000;
          rsum_d     = 32'h0000_0000;
          done_d     = 1'b0;
          err_d      = 1'b0;
          code_d     = ERR_NONE;
          pack_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_FILL: begin
        if (pack_full_s) begin
          state_d = ST_WR;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 4'hF;
          adr_d   = word_addr(BASE_ADDR, idx_q);
          dat_d   = pack_word_s;
          tmo_d   = 8'd0;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WR: begin
        if (wbm_ack_i) begin
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = 4'h0;
          adr_d  = 32'h0000_0000;
          dat_d  = 32'h0000_0000;
          wsum_d = wsum_q + dat_q;
          if (idx_q == IDX_LAST) begin
            idx_d   = 10'd0;
            state_d = ST_RD;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = ST_FILL;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          adr_d   = 32'h0000_0000;
          dat_d   = 32'h0000_0000;
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_WR_TMO;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_RD: begin
        // A read is launched only from an idle bus, so every read cycle is
        // preceded by at least one cycle with cyc low.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          sel_d = 4'hF;
          adr_d = word_addr(BASE_ADDR, idx_q);
          dat_d = 32'h0000_0000;
          tmo_d = 8'd0;
        end else if (wbm_ack_i) begin
          cyc_d  = 1'b0;
          sel_d  = 4'h0;
          adr_d  = 32'h0000_0000;
          rsum_d = rsum_q + wbm_dat_i;
          if (idx_q == IDX_LAST) begin
            idx_d   = 10'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = ST_RD;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          adr_d   = 32'h0000_0000;
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_RD_TMO;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_CHECK: begin
        if (wsum_q == rsum_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_CSUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = 4'h0;
        adr_d   = 32'h0000_0000;
        dat_d   = 32'h0000_0000;
      end
    endcase
  end

  // State, bus and status registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0000_0000;
      dat_q   <= 32'h0000_0000;
      idx_q   <= 10'd0;
      tmo_q   <= 8'd0;
      wsum_q  <= 32'h0000_0000;
      rsum_q  <= 32'h0000_0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ready_q <= (state_d == ST_FILL);
      busy_q  <= (state_d == ST_FILL) || (state_d == ST_WR) ||
                 (state_d == ST_RD)   || (state_d == ST_CHECK);
    end
  end

  assign byte_ready_o = ready_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;

endmodule

// File: tb/tb_wb_rom_loader.sv
// Scoreboard bench for wb_rom_loader (WORDS=2, TIMEOUT=4).
module tb_wb_rom_loader;

  localparam int          WORDS = 2;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          TMO   = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, bvalid, bready;
  logic [7:0]  bdata;
  logic        cyc, stb, we, busy, done, err;
  logic        ack = 1'b0;
  logic [31:0] adr, dato, dati;
  logic [3:0]  sel;
  logic [1:0]  code;

  always #5 clk = ~clk;

  wb_rom_loader #(.WORDS(WORDS), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start),
    .byte_i(bdata), .byte_valid_i(bvalid), .byte_ready_o(bready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dato), .wbm_sel_o(sel), .wbm_dat_i(dati), .wbm_ack_i(ack),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(code)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t       sb_q[$];
  logic [7:0]  stream [8];
  logic [31:0] exp_word [WORDS];
  int          ack_delay = 1;
  bit          no_ack = 1'b0;
  bit          corrupt = 1'b0;
  int          rcnt = 0;
  int          cyc_cycles = 0;

  // Responder: ack after ack_delay cycles of strobe; reads return the bench's words.
  always @(posedge clk) begin
    if (cyc && stb && !ack && !no_ack) begin
      if (rcnt >= ack_delay - 1) begin
        ack  <= 1'b1;
        rcnt <= 0;
      end else begin
        rcnt <= rcnt + 1;
      end
    end else begin
      ack  <= 1'b0;
      rcnt <= 0;
    end
  end

  always_comb begin
    dati = 32'h0;
    if (cyc && !we) begin
      dati = exp_word[adr[2]] ^ ((corrupt && adr == BASE) ? 32'h1 : 32'h0);
    end
  end

  // Monitor: compares completed transfers and bus-idle invariants.
  always @(negedge clk) begin
    xfer_t e;
    if (cyc) cyc_cycles++;
    if (cyc && stb && ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'(adr), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("xfer_we", 32'(we), 32'(e.we));
        check("xfer_adr", adr, e.adr);
        check("xfer_sel", 32'(sel), 32'hF);
        if (e.we) check("xfer_dat", dato, e.dat);
      end
    end
    if (cyc) check("ready_in_bus", 32'(bready), 32'h0);
    if (!cyc) begin
      check("adr_idle", adr, 32'h0);
      check("dat_idle", dato, 32'h0);
    end
  end

  task automatic push_expect();
    for (int w = 0; w < WORDS; w++)
      sb_q.push_back('{we: 1'b1, adr: BASE + 32'(4 * w), dat: exp_word[w]});
    for (int w = 0; w < WORDS; w++)
      sb_q.push_back('{we: 1'b0, adr: BASE + 32'(4 * w), dat: 32'h0});
  endtask

  task automatic drive_bytes(input int nbytes, input bit toggle, input bit inj);
    int i = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (i < nbytes && guard < 2000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (toggle && ph) begin
        bvalid = 1'b0;
      end else begin
        bvalid = 1'b1;
        bdata  = stream[i];
      end
      ph = ~ph;
      // ready is registered, so its value now holds at the next rising edge
      if (bvalid && bready) begin
        if (inj && i == 1) start = 1'b1;
        i++;
      end
    end
    if (i < nbytes) check("byte_budget", 32'(i), 32'(nbytes));
    @(negedge clk);
    bvalid = 1'b0;
    start  = 1'b0;
  endtask

  task automatic load(input int delay, input bit toggle, input bit inj, input int nbytes,
                      input bit push);
    ack_delay = delay;
    if (push) push_expect();
    @(negedge clk);
    start = 1'b1;
    drive_bytes(nbytes, toggle, inj);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) check("end_budget", 32'h0, 32'h1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"}, 32'(cyc), 32'h0);
    check({tag, "_stb"}, 32'(stb), 32'h0);
    check({tag, "_we"}, 32'(we), 32'h0);
    check({tag, "_sel"}, 32'(sel), 32'h0);
    check({tag, "_rdy"}, 32'(bready), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_code"}, 32'(code), 32'h0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic [1:0] c);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_code"}, 32'(code), 32'(c));
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_sb_left"}, 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    bvalid = 1'b0;
    bdata  = 8'h00;
    for (int i = 0; i < 8; i++) stream[i] = 8'(i + 1);
    for (int w = 0; w < WORDS; w++)
      exp_word[w] = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Basic load, ack one cycle after strobe
    load(1, 1'b0, 1'b0, 8, 1'b1);
    wait_end(300);
    check_status("basic", 1'b1, 1'b0, 2'd0);

    // Readback of word 0 off by one bit -> checksum error
    corrupt = 1'b1;
    load(1, 1'b0, 1'b0, 8, 1'b1);
    wait_end(300);
    check_status("csum", 1'b0, 1'b1, 2'd3);
    corrupt = 1'b0;

    // Gappy byte stream, slow responder
    load(3, 1'b1, 1'b0, 8, 1'b1);
    wait_end(400);
    check_status("slow", 1'b1, 1'b0, 2'd0);

    // Spurious start while filling
    load(1, 1'b0, 1'b1, 8, 1'b1);
    wait_end(300);
    check_status("inj", 1'b1, 1'b0, 2'd0);

    // First write never acknowledged
    no_ack = 1'b1;
    cyc_cycles = 0;
    load(1, 1'b0, 1'b0, 4, 1'b0);
    wait_end(100);
    check_status("tmo", 1'b0, 1'b1, 2'd1);
    check("tmo_cyc_cycles", 32'(cyc_cycles), 32'(TMO));
    check("tmo_cyc", 32'(cyc), 32'h0);
    no_ack = 1'b0;

    // Reset during the second write's strobe
    load(3, 1'b0, 1'b0, 8, 1'b1);
    n = 0;
    while (!(cyc && we && adr == BASE + 32'h4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_w1_seen", 32'(cyc && we && adr == BASE + 32'h4), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("midrst");
    check("midrst_adr", adr, 32'h0);
    check("midrst_sb_left", 32'(sb_q.size()), 32'h3);
    sb_q.delete();
    load(1, 1'b0, 1'b0, 8, 1'b1);
    wait_end(300);
    check_status("reload", 1'b1, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
